usr_burst: RTL

USR_BURST -- requirements
Module: usr_burst

---
 rtl/usr_burst_pkg.sv | 20 ++
 rtl/usr_rot.sv | 22 ++
 rtl/usr_burst.sv | 115 +++++++++++
 3 files changed

// File: rtl/usr_burst_pkg.sv
// Shared definitions for the usr_burst shift/rotate register: operation
// encodings and controller state enum.
package usr_burst_pkg;

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_SHR  = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_LOAD = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_ASR  = 3'b110;
    localparam logic [2:0] OP_NOP  = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/usr_rot.sv
// Combinational barrel rotator; dir=0 rotates right, dir=1 rotates left.
module usr_rot #(
    parameter int N  = 8,
    parameter int AW = $clog2(N)
) (
    input  logic [N-1:0]  data,
    input  logic [AW-1:0] amt,
    input  logic          dir,
    output logic [N-1:0]  rotated
);

    // N is a power of two, so AW-bit index arithmetic wraps modulo N for free.
    for (genvar gi = 0; gi < N; gi++) begin : g_bit
        localparam logic [AW-1:0] POS = AW'(gi);
        logic [AW-1:0] idx_right;
        logic [AW-1:0] idx_left;
        assign idx_right   = POS + amt;
        assign idx_left    = POS - amt;
        assign rotated[gi] = dir ? data[idx_left] : data[idx_right];
    end

endmodule

// File: rtl/usr_burst.sv
// Universal shift register with single-cycle ops and multi-cycle shift bursts.
// Define USR_BURST_ASR_EN to enable the arithmetic-shift-right op (110).
module usr_burst
    import usr_burst_pkg::*;
#(
    parameter int N  = 8,
    parameter int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [2:0]    op,
    input  logic [AW-1:0] amt,
    input  logic          start,
    input  logic          msb_in,
    input  logic          lsb_in,
    input  logic [N-1:0]  d,
    output logic [N-1:0]  q,
    output logic          msb_out,
    output logic          lsb_out,
    output logic          busy,
    output logic          done
);

    state_t        state_reg, state_next;
    logic [N-1:0]  q_reg, q_next;
    logic [AW-1:0] cnt_reg, cnt_next;
    logic          dir_reg, dir_next;

    logic [N-1:0]  shr_val;
    logic [N-1:0]  shl_val;
    logic [N-1:0]  rot_val;
    logic [N-1:0]  asr_val;

    assign shr_val = {msb_in, q_reg[N-1:1]};
    assign shl_val = {q_reg[N-2:0], lsb_in};

    usr_rot #(
        .N  (N),
        .AW (AW)
    ) u_rot (
        .data    (q_reg),
        .amt     (amt),
        .dir     (op == OP_ROL),
        .rotated (rot_val)
    );

`ifdef USR_BURST_ASR_EN
    assign asr_val = $signed(q_reg) >>> amt;
`else
    assign asr_val = q_reg;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            q_reg     <= '0;
            cnt_reg   <= '0;
            dir_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            q_reg     <= q_next;
            cnt_reg   <= cnt_next;
            dir_reg   <= dir_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        q_next     = q_reg;
        cnt_next   = cnt_reg;
        dir_next   = dir_reg;
        case (state_reg)
            IDLE: begin
                if (start && (amt != '0) && ((op == OP_SHR) || (op == OP_SHL))) begin
                    // Burst entry cycle only latches; the first shift happens next edge.
                    state_next = BURST;
                    cnt_next   = amt;
                    dir_next   = (op == OP_SHL);
                end else begin
                    case (op)
                        OP_SHR:  q_next = shr_val;
                        OP_SHL:  q_next = shl_val;
                        OP_LOAD: q_next = d;
                        OP_ROR:  q_next = rot_val;
                        OP_ROL:  q_next = rot_val;
                        OP_ASR:  q_next = asr_val;
                        default: q_next = q_reg;
                    endcase
                end
            end
            BURST: begin
                q_next   = dir_reg ? shl_val : shr_val;
                cnt_next = cnt_reg - AW'(1);
                if (cnt_reg == AW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign q       = q_reg;
    assign msb_out = q_reg[N-1];
    assign lsb_out = q_reg[0];
    assign busy    = (state_reg == BURST);
    assign done    = (state_reg == DONE);

endmodule
